// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
// dac_pkg : shared types, frame constants and sample conversion for dac_spi_out
// Revision: 1.0
// ============================================================================
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } dac_state_t;

  localparam int         FRAME_W     = 16;
  localparam logic [3:0] CTRL_NIBBLE = 4'b0011;

  // Sign-extending attenuation followed by MSB flip into offset binary.
  function automatic logic [7:0] dac_convert(input logic [7:0] sample,
                                             input logic [1:0] amp);
    logic signed [7:0] w_shifted;
    w_shifted = $signed(sample) >>> amp;
    return w_shifted ^ 8'h80;
  endfunction

  function automatic logic [FRAME_W-1:0] dac_frame(input logic [7:0] data);
    return {CTRL_NIBBLE, data, 4'b0000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dac_sclk_gen.sv
`default_nettype none
// ============================================================================
// dac_sclk_gen : SCLK divider with one-cycle rise/fall enables; held low
//                whenever i_en is deasserted.
// Revision: 1.0
// ============================================================================
module dac_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int                c_cnt_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(CLK_DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_sclk;
  logic               w_wrap;

  // The enables fire in the cycle before the level actually toggles.
  assign w_wrap = i_en && (r_cnt == c_cnt_max);
  assign o_rise = w_wrap && !r_sclk;
  assign o_fall = w_wrap && r_sclk;
  assign o_sclk = r_sclk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dac_spi_out.sv
`default_nettype none
// ============================================================================
// dac_spi_out : attenuate/convert oscillator samples and serialise them as
//               16-bit SPI frames; optional DAC_OVERRUN_CNT_EN adds overrun_cnt.
// Revision: 1.0
// ============================================================================
module dac_spi_out
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  input  logic [1:0] amp_sel,
  output logic       dac_sclk,
  output logic       dac_cs_n,
  output logic       dac_mosi,
  output logic       busy,
  output logic       overrun
`ifdef DAC_OVERRUN_CNT_EN
  ,
  output logic [7:0] overrun_cnt
`endif
);

  localparam int                c_gap_w    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(CS_GAP - 1);

  dac_state_t          r_state;
  logic [7:0]          r_cur;
  logic [7:0]          r_pend;
  logic                r_pend_vld;
  logic [FRAME_W-1:0]  r_shift;
  logic [3:0]          r_bit;
  logic [c_gap_w-1:0]  r_gap_cnt;
  logic                r_cs_n;
  logic                r_busy;
  logic                r_overrun;

  logic                w_sclk_en;
  logic                w_rise;
  logic                w_fall;
  logic [7:0]          w_conv;
  logic                w_gap_done;
  logic                w_take_pend;
  logic                w_overwrite;

  assign w_conv      = dac_convert(sample_in, amp_sel);
  assign w_sclk_en   = (r_state == SHIFT);
  assign w_gap_done  = (r_state == GAP) && (r_gap_cnt == c_gap_last);
  // The pending slot drains in IDLE or on GAP exit; a strobe then refills it
  // without counting as an overwrite.
  assign w_take_pend = r_pend_vld && ((r_state == IDLE) || w_gap_done);
  assign w_overwrite = sample_valid && r_pend_vld && !w_take_pend;

  dac_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_sclk_en),
    .o_sclk (dac_sclk),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cur      <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_shift    <= '0;
      r_bit      <= '0;
      r_gap_cnt  <= '0;
      r_cs_n     <= 1'b1;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (sample_valid && ((r_state != IDLE) || r_pend_vld)) begin
        r_pend     <= w_conv;
        r_pend_vld <= 1'b1;
      end else if (w_take_pend) begin
        r_pend_vld <= 1'b0;
      end

      if (w_overwrite) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (r_pend_vld) begin
            r_cur   <= r_pend;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end else if (sample_valid) begin
            r_cur   <= w_conv;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end

        LOAD: begin
          r_shift <= dac_frame(r_cur);
          r_bit   <= '0;
          r_cs_n  <= 1'b0;
          r_state <= SHIFT;
        end

        SHIFT: begin
          if (w_rise) begin
            r_bit <= r_bit + 1'b1;
          end
          // r_bit wraps to zero after the 16th rising edge.
          if (w_fall) begin
            if (r_bit == 4'd0) begin
              r_shift   <= '0;
              r_cs_n    <= 1'b1;
              r_gap_cnt <= '0;
              r_state   <= GAP;
            end else begin
              r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
            end
          end
        end

        GAP: begin
          if (w_gap_done) begin
            if (r_pend_vld) begin
              r_cur   <= r_pend;
              r_state <= LOAD;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign dac_cs_n = r_cs_n;
  assign dac_mosi = r_shift[FRAME_W-1];
  assign busy     = r_busy;
  assign overrun  = r_overrun;

`ifdef DAC_OVERRUN_CNT_EN
  logic [7:0] r_ovr_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovr_cnt <= '0;
    end else if (w_overwrite && (r_ovr_cnt != 8'hFF)) begin
      r_ovr_cnt <= r_ovr_cnt + 1'b1;
    end
  end

  assign overrun_cnt = r_ovr_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_out.sv
`default_nettype none
// ============================================================================
// tb_dac_spi_out : directed self-checking bench for dac_spi_out
// Revision: 1.0
// ============================================================================
module tb_dac_spi_out;

  localparam int c_div     = 4;
  localparam int c_gap     = 2;
  localparam int c_len     = 32 * c_div;
  localparam int c_spacing = c_len + c_gap + 1;

  logic       clk          = 1'b0;
  logic       rst          = 1'b0;
  logic [7:0] sample_in    = '0;
  logic       sample_valid = 1'b0;
  logic [1:0] amp_sel      = '0;
  logic       dac_sclk;
  logic       dac_cs_n;
  logic       dac_mosi;
  logic       busy;
  logic       overrun;
`ifdef DAC_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int base;

  dac_spi_out #(
    .CLK_DIV (c_div),
    .CS_GAP  (c_gap)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .amp_sel      (amp_sel),
    .dac_sclk     (dac_sclk),
    .dac_cs_n     (dac_cs_n),
    .dac_mosi     (dac_mosi),
    .busy         (busy),
    .overrun      (overrun)
`ifdef DAC_OVERRUN_CNT_EN
    ,
    .overrun_cnt  (overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Frame monitor: shifts mosi in on each rising sclk while cs_n is low.
  logic [15:0] cap;
  int          nbits;
  time         t_fall;
  logic [15:0] frames[$];
  int          lens[$];
  int          bitcnt[$];
  time         starts[$];

  always @(negedge dac_cs_n) begin
    t_fall = $time;
    cap    = '0;
    nbits  = 0;
  end

  always @(posedge dac_sclk) begin
    if (!dac_cs_n) begin
      cap   = {cap[14:0], dac_mosi};
      nbits = nbits + 1;
    end
  end

  always @(posedge dac_cs_n) begin
    if (rst) begin
      frames.push_back(cap);
      lens.push_back(int'(($time - t_fall) / 10));
      bitcnt.push_back(nbits);
      starts.push_back(t_fall);
    end
  end

  function automatic logic [15:0] fr(input int i);
    return (i < frames.size()) ? frames[i] : 16'hxxxx;
  endfunction

  function automatic logic [31:0] ln(input int i);
    return (i < lens.size()) ? 32'(lens[i]) : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] bc(input int i);
    return (i < bitcnt.size()) ? 32'(bitcnt[i]) : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] gap_between(input int i);
    return (i + 1 < starts.size()) ? 32'((starts[i+1] - starts[i]) / 10) : 32'hxxxx_xxxx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] s, input logic [1:0] a);
    sample_in    = s;
    amp_sel      = a;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string tag);
    for (int i = 0; i < 600 && frames.size() < n; i++) tick();
    chk(tag, 32'(frames.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 600 && busy !== 1'b0; i++) tick();
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_cs_n", 32'(dac_cs_n), 32'd1);
    chk("rst_sclk", 32'(dac_sclk), 32'd0);
    chk("rst_mosi", 32'(dac_mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b1;
    repeat (5) tick();
    chk("idle_cs_n", 32'(dac_cs_n), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // 0x40, no attenuation, with start-of-frame timing
    base = frames.size();
    send(8'h40, 2'd0);
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_cs_n", 32'(dac_cs_n), 32'd1);
    tick();
    chk("start_cs_n", 32'(dac_cs_n), 32'd0);
    chk("start_mosi", 32'(dac_mosi), 32'd0);
    chk("start_sclk", 32'(dac_sclk), 32'd0);
    repeat (c_div - 1) tick();
    chk("sclk_low_phase", 32'(dac_sclk), 32'd0);
    tick();
    chk("sclk_first_rise", 32'(dac_sclk), 32'd1);
    wait_frames(base + 1, "timeout_f40");
    chk("frame_40", 32'(fr(base)), 32'h3C00);
    chk("len_40", ln(base), 32'(c_len));
    chk("bits_40", bc(base), 32'd16);
    wait_idle("idle_f40");

    // Attenuated samples
    base = frames.size();
    send(8'h80, 2'd1);
    wait_frames(base + 1, "timeout_f80");
    chk("frame_80_s1", 32'(fr(base)), 32'h3400);
    wait_idle("idle_f80");

    base = frames.size();
    send(8'h7F, 2'd3);
    wait_frames(base + 1, "timeout_f7f");
    chk("frame_7f_s3", 32'(fr(base)), 32'h38F0);
    wait_idle("idle_f7f");

    // Overrun: A, B, C at cycles 0, 10, 20
    base = frames.size();
    send(8'h10, 2'd0);
    repeat (9) tick();
    send(8'h20, 2'd0);
    chk("no_ovr_after_b", 32'(overrun), 32'd0);
    repeat (9) tick();
    send(8'h30, 2'd0);
    chk("ovr_flag", 32'(overrun), 32'd1);
`ifdef DAC_OVERRUN_CNT_EN
    chk("ovr_cnt", 32'(overrun_cnt), 32'd1);
`endif
    wait_frames(base + 2, "timeout_ovr");
    wait_idle("idle_ovr");
    repeat (20) tick();
    chk("ovr_nframes", 32'(frames.size()), 32'(base + 2));
    chk("ovr_frame_a", 32'(fr(base)), 32'h3900);
    chk("ovr_frame_c", 32'(fr(base + 1)), 32'h3B00);
    chk("ovr_spacing", gap_between(base), 32'(c_spacing));
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-frame
    base = frames.size();
    send(8'h40, 2'd0);
    tick();
    chk("abort_cs_low", 32'(dac_cs_n), 32'd0);
    repeat (54) tick();
    chk("abort_pre_sclk", 32'(dac_sclk), 32'd1);
    rst = 1'b0;
    #2;
    chk("abort_cs_n", 32'(dac_cs_n), 32'd1);
    chk("abort_sclk", 32'(dac_sclk), 32'd0);
    chk("abort_mosi", 32'(dac_mosi), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ovr_clr", 32'(overrun), 32'd0);
`ifdef DAC_OVERRUN_CNT_EN
    chk("abort_ovr_cnt_clr", 32'(overrun_cnt), 32'd0);
`endif
    tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("abort_no_frame", 32'(frames.size()), 32'(base));
    send(8'h7F, 2'd0);
    wait_frames(base + 1, "timeout_post_rst");
    chk("post_rst_frame", 32'(fr(base)), 32'h3FF0);
    chk("post_rst_len", ln(base), 32'(c_len));
    wait_idle("idle_post_rst");

    // Strobe on the exact GAP-exit cycle with pending valid
    base = frames.size();
    send(8'h11, 2'd0);
    repeat (20) tick();
    send(8'h22, 2'd0);
    repeat (109) tick();
    chk("gapx_cs_high", 32'(dac_cs_n), 32'd1);
    chk("gapx_busy", 32'(busy), 32'd1);
    send(8'hF0, 2'd2);
    wait_frames(base + 3, "timeout_gapx");
    wait_idle("idle_gapx");
    chk("gapx_frame_x", 32'(fr(base)), 32'h3910);
    chk("gapx_frame_y", 32'(fr(base + 1)), 32'h3A20);
    chk("gapx_frame_z", 32'(fr(base + 2)), 32'h37C0);
    chk("gapx_spacing_xy", gap_between(base), 32'(c_spacing));
    chk("gapx_spacing_yz", gap_between(base + 1), 32'(c_spacing));
    chk("gapx_no_ovr", 32'(overrun), 32'd0);
`ifdef DAC_OVERRUN_CNT_EN
    chk("gapx_ovr_cnt", 32'(overrun_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
